conv3x3_pool_stream: RTL and testbench
======================================

Name: conv3x3_pool_stream

Overview:
- Streaming 3x3 convolution engine with optional 2x2/stride-2 max pooling. It is the parametrised successor of the fixed 14x14 convolution block.
- Accepts one IFM pixel per accepted cycle in raster order, with the 9 kernel weights loaded on the first 9 accepted cycles of each frame.
- Uses two line buffers plus a 3x3 window register, so no full-frame storage.
- Sits between the IFM source and the OFM sink of the accelerator datapath.

Parameters:
- IMG_W, 14: IFM width in pixels (>=3).
- IMG_H, 14: IFM height in pixels (>=3).
- DATA_W, 16: IFM pixel and weight width, unsigned.
- OUT_W, 2*DATA_W+4: output width; always holds 9 full products without overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel (and weight, during the first 9 beats) present this cycle.
- In_IFM  in  DATA_W  IFM pixel.
- In_Weight  in  DATA_W  kernel weight; sampled only on beats 0..8 of a frame.
- pool_en  in  1  mode select; sampled on beat 0 of each frame, held internally for the whole frame.
- out_valid  out  1  Out_OFM valid this cycle.
- Out_OFM  out  OUT_W  convolution or pooled result.
- frame_done  out  1  one-cycle pulse coincident with the last output of the frame.

Behaviour:
- Reset: out_valid=0, Out_OFM=0, frame_done=0. All counters, window registers, line buffers, weights and the mode latch are cleared. Reset mid-frame abandons the frame; the next accepted beat is beat 0 of a new frame.
- Stream: row/col counters advance only on in_valid=1. Gaps of any length are allowed and do not alter results; there is no backpressure.
- Weights: beat k (k=0..8) writes weight k in kernel raster order (w0 top-left .. w8 bottom-right). The pixel on those beats is also consumed as image data.
- Window: two line buffers of IMG_W entries plus a 3x3 shift window. The window becomes valid when the accepted pixel has row>=2 and col>=2; it then covers rows r-2..r and columns c-2..c. Windows never wrap across a row boundary.
- Arithmetic: unsigned sum of w_i*p_i over 9 terms, computed at full OUT_W precision; no truncation or saturation.
- Pipeline: stage 1 registers the 9 products; stage 2 registers the sum to Out_OFM. With pool_en=0, out_valid asserts exactly 2 cycles after the beat that completes the window, regardless of later input gaps. Output order is raster, (IMG_H-2)*(IMG_W-2) results per frame.
- Pooling (pool_en latched 1):
  - Conv results are grouped into 2x2 blocks at even conv row/col.
  - A partial-max buffer of (IMG_W-2)/2 entries holds the max of each even conv row pair.
  - On the odd conv row, the odd-column result completes a block. The pooled max is emitted 1 cycle after that conv result would have been emitted (latency 3 from the completing pixel).
  - ((IMG_H-2)/2)*((IMG_W-2)/2) outputs per frame. If IMG_W-2 or IMG_H-2 is odd, the trailing conv column/row is discarded.
  - Comparison is unsigned; on ties any equal value is output.
- Frame end: frame_done pulses with the final out_valid of the frame. The beat after the last pixel (IMG_W*IMG_H beats) is beat 0 of the next frame: weights and pool_en are reloaded, and the line buffers are treated as empty.
- Back-to-back frames: in-flight outputs of frame N complete with unchanged latency while frame N+1 loads. Weights and mode used for frame N are those latched at frame N's beat 0..8, even if the next frame's weight load overlaps frame N's pipeline drain.
- Between frames out_valid=0. Out_OFM holds its last value when out_valid=0.

Test Plan:
- Default 14x14, pool_en=0, all pixels=1, all weights=1 -> 144 outputs of 9, first out_valid 2 cycles after beat 30, frame_done on the 144th output.
- Pixel=column index (0..13), w4=1 and other weights 0, pool_en=0 -> each output row is 1,2,..,12. With pool_en=1 -> 36 outputs, each row 2,4,6,8,10,12, first output at latency 3 after beat 45.
- All pixels=65535, all weights=65535 -> every output equals 38653526025, with no overflow in 36 bits.
- Random in_valid gaps (30% idle) with random data -> output sequence identical to the gap-free reference model, and each out_valid exactly 2 (or 3) cycles after its completing beat.
- Two back-to-back frames with different weights and pool_en 0 then 1 -> 144 then 36 outputs, each computed with its own frame's weights and mode, and two frame_done pulses.
- Assert rst_n low at beat 100 of a frame -> outputs immediately 0. A subsequent full frame (all 2s, weights 1) gives 144 outputs of 18 with no stale-data corruption.

Source files
------------

// File: rtl/conv3x3_pool_stream.sv
// Streaming 3x3 convolution with optional 2x2/stride-2 max pooling.
// Two line buffers feed a sliding window; pipeline is products -> sum -> pooled max.
module conv3x3_pool_stream #(
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 2*DATA_W+4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_IFM,
  input  logic [DATA_W-1:0] In_Weight,
  input  logic              pool_en,
  output logic              out_valid,
  output logic [OUT_W-1:0]  Out_OFM,
  output logic              frame_done
);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int PW     = (IMG_W-2)/2;
  localparam int PH     = (IMG_H-2)/2;
  localparam int PB     = (PW > 1) ? PW : 1;
  localparam int PIW    = (PB > 1) ? $clog2(PB) : 1;
  localparam int PROD_W = 2*DATA_W;

  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [3:0]        wcnt_q;
  logic              mode_q;
  logic [DATA_W-1:0] w_q   [9];
  logic [DATA_W-1:0] lb0_q [IMG_W];  // row r-1
  logic [DATA_W-1:0] lb1_q [IMG_W];  // row r-2
  logic [DATA_W-1:0] win_q [3][2];   // columns c-2, c-1; column c comes straight in

  logic              last_col, last_row, win_ok;
  logic [DATA_W-1:0] col_top, col_mid;
  logic [DATA_W-1:0] pix [9];
  logic [DATA_W-1:0] wt  [9];

  assign last_col = (col_q == CW'(IMG_W-1));
  assign last_row = (row_q == RW'(IMG_H-1));
  assign win_ok   = in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign col_top  = lb1_q[col_q];
  assign col_mid  = lb0_q[col_q];

  assign pix[0] = win_q[0][0];
  assign pix[1] = win_q[0][1];
  assign pix[2] = col_top;
  assign pix[3] = win_q[1][0];
  assign pix[4] = win_q[1][1];
  assign pix[5] = col_mid;
  assign pix[6] = win_q[2][0];
  assign pix[7] = win_q[2][1];
  assign pix[8] = In_IFM;

  // Bypass the weight being loaded this beat (w8 meets the first window when IMG_W=3).
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      wt[k] = (wcnt_q == 4'(k)) ? In_Weight : w_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      wcnt_q <= '0;
      mode_q <= 1'b0;
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
      // NOTE: line buffers are flops here, so they take the async reset like any other state.
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (in_valid) begin
      if (wcnt_q < 4'd9) begin
        for (int k = 0; k < 9; k++) begin
          if (wcnt_q == 4'(k)) w_q[k] <= In_Weight;
        end
        wcnt_q <= wcnt_q + 4'd1;
      end
      if (wcnt_q == 4'd0) mode_q <= pool_en;
      lb1_q[col_q] <= col_mid;
      lb0_q[col_q] <= In_IFM;
      win_q[0][0]  <= win_q[0][1];
      win_q[1][0]  <= win_q[1][1];
      win_q[2][0]  <= win_q[2][1];
      win_q[0][1]  <= col_top;
      win_q[1][1]  <= col_mid;
      win_q[2][1]  <= In_IFM;
      if (last_col) begin
        col_q <= '0;
        if (last_row) begin
          row_q  <= '0;
          wcnt_q <= '0;
        end else begin
          row_q <= row_q + RW'(1);
        end
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Stage 1: products plus the mode/coordinates of this window travel together,
  // so a following frame can reload weights and mode while this one drains.
  logic [PROD_W-1:0] prod_q [9];
  logic              s1_vld_q, s1_pool_q, s1_last_q;
  logic [RW-1:0]     s1_cr_q;
  logic [CW-1:0]     s1_cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      s1_vld_q  <= 1'b0;
      s1_pool_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_cr_q   <= '0;
      s1_cc_q   <= '0;
    end else begin
      s1_vld_q <= win_ok;
      if (win_ok) begin
        for (int k = 0; k < 9; k++) prod_q[k] <= PROD_W'(wt[k]) * PROD_W'(pix[k]);
        s1_pool_q <= mode_q;
        s1_last_q <= last_col && last_row;
        s1_cr_q   <= row_q - RW'(2);
        s1_cc_q   <= col_q - CW'(2);
      end
    end
  end

  logic [OUT_W-1:0] sum;
  // NOTE: combinational logic uses blocking assignments and defaults first, so no latch appears.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + OUT_W'(prod_q[k]);
  end

  // Stage 2 (conv output or pool input) and stage 3 (pooled max).
  logic [OUT_W-1:0] c2_q, hmax_q, pair, blk;
  logic [OUT_W-1:0] pbuf_q [PB];
  logic             c2_vld_q;
  logic [RW-1:0]    c2_cr_q;
  logic [CW-1:0]    c2_cc_q;
  logic [PIW-1:0]   pidx;

  assign pidx = PIW'(c2_cc_q >> 1);
  assign pair = (c2_q > hmax_q) ? c2_q : hmax_q;
  assign blk  = (pair > pbuf_q[pidx]) ? pair : pbuf_q[pidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      Out_OFM    <= '0;
      frame_done <= 1'b0;
      c2_q       <= '0;
      c2_vld_q   <= 1'b0;
      c2_cr_q    <= '0;
      c2_cc_q    <= '0;
      hmax_q     <= '0;
      for (int i = 0; i < PB; i++) pbuf_q[i] <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      c2_vld_q   <= 1'b0;
      if (s1_vld_q && !s1_pool_q) begin
        out_valid  <= 1'b1;
        Out_OFM    <= sum;
        frame_done <= s1_last_q;
      end
      // Trailing odd conv row/column never reaches the pool stage.
      if (s1_vld_q && s1_pool_q && (s1_cr_q < RW'(2*PH)) && (s1_cc_q < CW'(2*PW))) begin
        c2_vld_q <= 1'b1;
        c2_q     <= sum;
        c2_cr_q  <= s1_cr_q;
        c2_cc_q  <= s1_cc_q;
      end
      if (c2_vld_q) begin
        if (!c2_cc_q[0]) begin
          hmax_q <= c2_q;
        end else if (!c2_cr_q[0]) begin
          pbuf_q[pidx] <= pair;
        end else begin
          out_valid  <= 1'b1;
          Out_OFM    <= blk;
          frame_done <= (c2_cr_q == RW'(2*PH-1)) && (c2_cc_q == CW'(2*PW-1));
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pool_stream.sv
// Directed bench for conv3x3_pool_stream: a reference model queues each expected
// output with its due cycle; a monitor checks value, latency and frame_done.
`timescale 1ns/1ps
module tb_conv3x3_pool_stream;
  localparam int W  = 14;
  localparam int H  = 14;
  localparam int DW = 16;
  localparam int OW = 2*DW+4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          pool_en = 1'b0;
  logic [DW-1:0] In_IFM = '0;
  logic [DW-1:0] In_Weight = '0;
  logic          out_valid, frame_done;
  logic [OW-1:0] Out_OFM;

  conv3x3_pool_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .In_IFM    (In_IFM),
    .In_Weight (In_Weight),
    .pool_en   (pool_en),
    .out_valid (out_valid),
    .Out_OFM   (Out_OFM),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    int          due;
    bit          last;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          mon_e;
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] wts [9];
  logic [63:0]   last_out = '0;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] conv_at(int cr, int cc);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += 64'(wts[i*3+j]) * 64'(img[cr+i][cc+j]);
    return s;
  endfunction

  function automatic logic [63:0] pool_at(int pr, int pc);
    logic [63:0] m, v;
    m = '0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) begin
        v = conv_at(2*pr+a, 2*pc+b);
        if (v > m) m = v;
      end
    return m;
  endfunction

  // mode 0: constant k, 1: column index, 2: random
  task automatic fill_img(input int mode, input logic [DW-1:0] k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? k : (mode == 1) ? DW'(c) : DW'($urandom);
  endtask

  // mode 0: constant k, 1: centre tap only, 2: random
  task automatic fill_wts(input int mode, input logic [DW-1:0] k);
    for (int i = 0; i < 9; i++)
      wts[i] = (mode == 0) ? k : (mode == 1) ? ((i == 4) ? DW'(1) : DW'(0)) : DW'($urandom);
  endtask

  task automatic run_frame(input bit pool, input int gap_pct, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int   r, c, cr, cc;
      exp_t e;
      r  = b / W;
      c  = b % W;
      cr = r - 2;
      cc = c - 2;
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        in_valid  = 1'b0;
        In_IFM    = DW'($urandom);
        In_Weight = DW'($urandom);
        pool_en   = 1'($urandom);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      In_IFM    = img[r][c];
      In_Weight = (b < 9) ? wts[b] : DW'($urandom);
      pool_en   = (b == 0) ? pool : 1'($urandom);
      if (r >= 2 && c >= 2) begin
        if (!pool) begin
          e.val  = conv_at(cr, cc);
          e.due  = cyc + 2;
          e.last = (r == H-1) && (c == W-1);
          exp_q.push_back(e);
        end else if (cr[0] && cc[0] && cr < 2*((H-2)/2) && cc < 2*((W-2)/2)) begin
          e.val  = pool_at(cr/2, cc/2);
          e.due  = cyc + 3;
          e.last = (cr == 2*((H-2)/2)-1) && (cc == 2*((W-2)/2)-1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("ofm", 64'(Out_OFM), mon_e.val);
          check("latency", 64'(cyc), 64'(mon_e.due));
          check("frame_done", 64'(frame_done), 64'(mon_e.last));
          last_out = mon_e.val;
        end
      end else begin
        check("hold", 64'(Out_OFM), last_out);
        check("fd_idle", 64'(frame_done), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ofm", 64'(Out_OFM), 64'd0);
    check("rst_fdone", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // all ones: 144 outputs of 9
    fill_img(0, DW'(1)); fill_wts(0, DW'(1));
    run_frame(1'b0, 0, W*H); drain();

    // column ramp with centre tap: rows 1..12, pooled rows 2,4,..,12
    fill_img(1, '0); fill_wts(1, '0);
    run_frame(1'b0, 0, W*H); drain();
    run_frame(1'b1, 0, W*H); drain();

    // full-scale operands: 38653526025 per output
    fill_img(0, DW'(16'hFFFF)); fill_wts(0, DW'(16'hFFFF));
    run_frame(1'b0, 0, W*H); drain();

    // random data with ~30% idle cycles, both modes
    fill_img(2, '0); fill_wts(2, '0);
    run_frame(1'b0, 30, W*H); drain();
    fill_img(2, '0); fill_wts(2, '0);
    run_frame(1'b1, 30, W*H); drain();

    // back-to-back frames, conv then pool, different weights
    fill_img(2, '0); fill_wts(2, '0);
    run_frame(1'b0, 0, W*H);
    fill_img(2, '0); fill_wts(2, '0);
    run_frame(1'b1, 0, W*H); drain();

    // reset at beat 100, then a clean frame of 2s with unit weights
    fill_img(0, DW'(3)); fill_wts(0, DW'(1));
    run_frame(1'b0, 0, 100);
    @(negedge clk);
    mon_en   = 1'b0;
    in_valid = 1'b1;
    In_IFM   = img[7][2];
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ofm", 64'(Out_OFM), 64'd0);
    check("midrst_fdone", 64'(frame_done), 64'd0);
    exp_q.delete();
    last_out = '0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    fill_img(0, DW'(2)); fill_wts(0, DW'(1));
    run_frame(1'b0, 0, W*H); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
